bcd_counter_n: RTL
==================

Name: bcd_counter_n

Overview:
- Parametrised multi-digit BCD counter; the successor to the fixed two-digit 0..99 counter.
- Adds the following over that counter:
  - configurable digit count and terminal value (e.g. 59 for minutes/seconds),
  - up/down direction,
  - synchronous parallel load,
  - wrap or saturate mode,
  - registered terminal-count pulse and sticky overflow flag.
- Used as a building block for timers and digit displays; cascades via tc.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); count width is 4*DIGITS.
- TOP, 99, terminal count in decimal (1..10^DIGITS-1); range is 0..TOP.
- WRAP_DEFAULT, 1, reset value of the internal mode register (1 = wrap, 0 = saturate).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  count enable; one step per clock while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- load_val  input  4*DIGITS  BCD value to load, digit 0 in bits [3:0]
- mode_wr  input  1  writes mode_in into the mode register
- mode_in  input  1  1 = wrap, 0 = saturate
- clear_ovf  input  1  clears ovf
- count  output  4*DIGITS  current BCD value, registered
- tc  output  1  registered one-cycle boundary pulse
- ovf  output  1  sticky boundary flag

Behaviour:
- Reset (asynchronous, any time, including mid-count):
  - count=0, tc=0, ovf=0, mode=WRAP_DEFAULT.
  - Outputs take their reset values immediately, independent of clk.
- All other updates occur on the rising clk edge; all outputs are registered.
- Priority per edge: load > en. mode_wr and clear_ovf are independent of both.
- Load:
  - count <= load_val, sanitised per digit: any digit >9 becomes 9.
  - After sanitising, a whole value >TOP becomes TOP.
  - Load never asserts tc and never changes ovf.
- Count, en=1 and load=0. Decimal ripple carry/borrow across digits; each digit stays in 0..9.
  - up=1, count<TOP: count+1.
  - up=1, count==TOP: wrap mode -> 0; saturate mode -> hold TOP.
  - up=0, count>0: count-1.
  - up=0, count==0: wrap mode -> TOP; saturate mode -> hold 0.
- Boundary event: a count step taken at count==TOP with up=1, or at count==0 with up=0.
  - tc=1 in the cycle after the event edge, i.e. coincident with the new count. It is 0 otherwise.
  - With en held high across consecutive boundary events (saturate mode), tc stays high on each of those cycles.
  - ovf is set by a boundary event.
  - clear_ovf clears ovf.
  - Set and clear on the same edge: set wins.
- en=0 and load=0: count holds, tc=0.
- A mode change takes effect from the next edge. A step on the same edge as mode_wr uses the old mode.
- Latency:
  - en to count change: 1 edge.
  - load to count: 1 edge.
  - No combinational path from any input to any output.
- Non-BCD internal values are unreachable. Ripple logic must be generated over DIGITS, not hand-unrolled.

Test Plan:
- DIGITS=2, TOP=99, wrap; reset, en=1, up=1 for 100 edges -> count 00,01..09,10..99, then 00 at edge 100. tc=1 only on the cycle count=00 appears; ovf=1 from then.
- TOP=59, wrap, up=0 from reset -> first edge gives count=59 with tc=1. After 59 more edges count=00 and tc=0. clear_ovf -> ovf=0 next cycle.
- Saturate mode, load 0x97, en=1, up=1 -> 98, 99, 99, 99. tc=1 on the 3rd and 4th cycles; ovf=1 and stays after en=0.
- Load sanitising with TOP=59:
  - load_val=0xA3 -> count=0x59 (digit 1 clamps to 9 giving 93, then >TOP clamps to 59).
  - load_val=0x4C -> count=0x49.
  - load with en=1 on the same edge -> loaded value, no step.
- Simultaneous events:
  - boundary step with clear_ovf on the same edge -> ovf=1.
  - mode_wr(0) on the same edge as a wrap step at 99 -> count=00, then saturate from the next edge.
- Assert reset asynchronously mid-count at count=0x37 between clock edges -> count=00, tc=0, ovf=0, mode=WRAP_DEFAULT immediately. Counting resumes from 00 on the first edge after release.

Source files
------------

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: parametrised multi-digit BCD up/down counter with load, wrap/saturate mode, tc pulse and sticky ovf
//   clk, reset (async, active-high)
//   en, up          : count enable and direction
//   load, load_val  : synchronous BCD load (sanitised, clamped to TOP)
//   mode_wr, mode_in: mode register write (1 = wrap, 0 = saturate)
//   clear_ovf       : clears the sticky overflow flag
//   count, tc, ovf  : registered BCD value, boundary pulse, sticky boundary flag
module bcd_counter_n #(
  parameter int DIGITS = 2,
  parameter int TOP = 99,
  parameter int WRAP_DEFAULT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                mode_wr,
  input  logic                mode_in,
  input  logic                clear_ovf,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                ovf
);
  localparam int W = 4*DIGITS;
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction
  localparam logic [W-1:0] TOP_BCD = to_bcd(TOP);
  logic [W-1:0] inc, dec, san, ld_val;
  logic [DIGITS-1:0] ci, bi;
  logic mode, at_top, at_zero, step, hit;
  assign ci[0] = 1'b1;
  assign bi[0] = 1'b1;
  genvar g;
  for (g = 0; g < DIGITS; g++) begin : dig
    logic [3:0] d, l;
    assign d = count[4*g+:4];
    assign l = load_val[4*g+:4];
    assign inc[4*g+:4] = ci[g] ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
    assign dec[4*g+:4] = bi[g] ? (d == 4'd0 ? 4'd9 : d - 4'd1) : d;
    assign san[4*g+:4] = l > 4'd9 ? 4'd9 : l;
    if (g < DIGITS-1) begin : chain
      assign ci[g+1] = ci[g] & (d == 4'd9);
      assign bi[g+1] = bi[g] & (d == 4'd0);
    end
  end
  // valid BCD orders the same as unsigned binary, so a plain compare clamps to TOP
  assign ld_val = san > TOP_BCD ? TOP_BCD : san;
  assign at_top = count == TOP_BCD;
  assign at_zero = count == '0;
  assign step = en & ~load;
  assign hit = step & (up ? at_top : at_zero);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tc <= 1'b0;
      ovf <= 1'b0;
      mode <= 1'(WRAP_DEFAULT);
    end else begin
      if (mode_wr) mode <= mode_in;
      tc <= hit;
      ovf <= hit | (ovf & ~clear_ovf);
      if (load) count <= ld_val;
      else if (en) count <= up ? (at_top ? (mode ? '0 : TOP_BCD) : inc)
                               : (at_zero ? (mode ? TOP_BCD : '0) : dec);
    end
  end
endmodule
